// File: rtl/bf_pkg.sv
// bfX sequencer shared definitions.
// Opcodes, state encoding, decoded-op bundle.
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_JZ    = 8'h5B;
  localparam logic [7:0] OP_JNZ   = 8'h5D;
  localparam logic [7:0] OP_END   = 8'h00;

  localparam int DEF_CODE_BASE = 0;
  localparam int DEF_CODE_LEN  = 256;
  localparam int DEF_DATA_BASE = 256;
  localparam int DEF_DATA_LEN  = 256;
  localparam int DEF_DEPTH_W   = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_SFETCH,
    S_SCHECK,
    S_OUT_WAIT,
    S_IN_WAIT,
    S_HALT,
    S_ERROR
  } bf_state_t;

  typedef struct packed {
    logic inc;
    logic dec;
    logic right;
    logic left;
    logic out;
    logic inp;
    logic jz;
    logic jnz;
    logic fin;
    logic nop;
  } op_t;

endpackage

// File: rtl/bf_decode.sv
// Byte to one-hot opcode decoder.
// Any unrecognised byte decodes as a NOP.
module bf_decode
  import bf_pkg::*;
(
  input  logic [7:0] byte_in,
  output op_t        op
);

  always_comb begin
    op = '0;
    unique case (1'b1)
      (byte_in == OP_INC):   op.inc   = 1'b1;
      (byte_in == OP_DEC):   op.dec   = 1'b1;
      (byte_in == OP_RIGHT): op.right = 1'b1;
      (byte_in == OP_LEFT):  op.left  = 1'b1;
      (byte_in == OP_OUT):   op.out   = 1'b1;
      (byte_in == OP_IN):    op.inp   = 1'b1;
      (byte_in == OP_JZ):    op.jz    = 1'b1;
      (byte_in == OP_JNZ):   op.jnz   = 1'b1;
      (byte_in == OP_END):   op.fin   = 1'b1;
      default:               op.nop   = 1'b1;
    endcase
  end

endmodule

// File: rtl/bf_seq.sv
// bfX instruction sequencer: fetch/exec loop,
// bracket scanning and byte-stream handshakes.
module bf_seq
  import bf_pkg::*;
#(
  parameter int CODE_BASE = DEF_CODE_BASE,
  parameter int CODE_LEN  = DEF_CODE_LEN,
  parameter int DATA_BASE = DEF_DATA_BASE,
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int DEPTH_W   = DEF_DEPTH_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] code_addr,
  output logic [15:0] data_addr,
  input  logic [7:0]  code_in,
  input  logic [7:0]  data_in,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        halted,
  output logic        error
);

  localparam logic [15:0] CB      = 16'(CODE_BASE);
  localparam logic [15:0] DB      = 16'(DATA_BASE);
  localparam logic [15:0] LAST_IP = 16'(CODE_LEN - 1);
  localparam logic [15:0] DP_MASK = 16'(DATA_LEN - 1);
  localparam logic [DEPTH_W-1:0] D_MAX = '1;
  localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);

  bf_state_t state;
  logic [15:0] ip;
  logic [15:0] dp;
  logic [DEPTH_W-1:0] depth;
  logic fwd;
  logic [7:0] out_q;

  op_t op;
  bf_decode u_dec (
    .byte_in(code_in),
    .op     (op)
  );

  logic [15:0] nxt_ip;
  bf_state_t   nxt_st;
  logic [15:0] step_ip;
  logic        step_ok;
  logic        open_tok;
  logic        close_tok;
  logic        at_last;
  logic        cell_zero;
  logic [15:0] dp_inc;
  logic [15:0] dp_dec;

  assign at_last   = (ip == LAST_IP);
  assign cell_zero = (data_in == 8'h00);
  assign dp_inc    = (dp + 16'd1) & DP_MASK;
  assign dp_dec    = (dp - 16'd1) & DP_MASK;

  // Normal-flow advance halts instead of running off the code end.
  always_comb begin
    nxt_ip    = ip + 16'd1;
    nxt_st    = S_FETCH;
    if (at_last) begin
      nxt_ip = ip;
      nxt_st = S_HALT;
    end
    open_tok  = fwd ? op.jz : op.jnz;
    close_tok = fwd ? op.jnz : op.jz;
    step_ok   = fwd ? !at_last : (ip != 16'd0);
    step_ip   = fwd ? ip + 16'd1 : ip - 16'd1;
  end

  assign code_addr = CB + ip;
  assign data_addr = DB + dp;
  assign wr_addr   = data_addr;
  assign out_valid = (state == S_OUT_WAIT);
  assign out_data  = out_q;
  assign in_ready  = (state == S_IN_WAIT);
  assign halted    = (state == S_HALT);
  assign error     = (state == S_ERROR);
  assign busy      = !(state inside {S_IDLE, S_HALT, S_ERROR});

  always_comb begin
    wr_en   = 1'b0;
    wr_data = 8'h00;
    if (rst_n) begin
      if (state == S_EXEC && op.inc) begin
        wr_en   = 1'b1;
        wr_data = data_in + 8'd1;
      end else if (state == S_EXEC && op.dec) begin
        wr_en   = 1'b1;
        wr_data = data_in - 8'd1;
      end else if (state == S_IN_WAIT && in_valid) begin
        wr_en   = 1'b1;
        wr_data = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ip    <= '0;
      dp    <= '0;
      depth <= '0;
      fwd   <= 1'b0;
      out_q <= 8'h00;
    end else begin
      unique case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            ip    <= '0;
            dp    <= '0;
            depth <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          unique case (1'b1)
            op.fin: state <= S_HALT;
            op.out: begin
              out_q <= data_in;
              state <= S_OUT_WAIT;
            end
            op.inp: state <= S_IN_WAIT;
            (op.jz && cell_zero): begin
              depth <= D_ONE;
              fwd   <= 1'b1;
              if (at_last) state <= S_ERROR;
              else begin
                ip    <= ip + 16'd1;
                state <= S_SFETCH;
              end
            end
            (op.jnz && !cell_zero): begin
              depth <= D_ONE;
              fwd   <= 1'b0;
              if (ip == 16'd0) state <= S_ERROR;
              else begin
                ip    <= ip - 16'd1;
                state <= S_SFETCH;
              end
            end
            default: begin
              if (op.right) dp <= dp_inc;
              if (op.left)  dp <= dp_dec;
              ip    <= nxt_ip;
              state <= nxt_st;
            end
          endcase
        end
        S_SFETCH: state <= S_SCHECK;
        S_SCHECK: begin
          unique case (1'b1)
            op.fin: state <= S_ERROR;
            (open_tok && depth == D_MAX): state <= S_ERROR;
            (close_tok && depth == D_ONE): begin
              depth <= '0;
              ip    <= nxt_ip;
              state <= nxt_st;
            end
            default: begin
              if (open_tok)       depth <= depth + D_ONE;
              else if (close_tok) depth <= depth - D_ONE;
              if (step_ok) begin
                ip    <= step_ip;
                state <= S_SFETCH;
              end else begin
                state <= S_ERROR;
              end
            end
          endcase
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            ip    <= nxt_ip;
            state <= nxt_st;
          end
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            ip    <= nxt_ip;
            state <= nxt_st;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_seq.sv
// Directed bench for bf_seq with a two-read-port memory
// model and an output-stream scoreboard.
module tb_bf_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] code_addr, data_addr, wr_addr;
  logic [7:0]  code_in, data_in, wr_data;
  logic        wr_en;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy, halted, error;

  bf_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .code_addr(code_addr),
    .data_addr(data_addr),
    .code_in  (code_in),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .halted   (halted),
    .error    (error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  logic       tb_we = 1'b0;
  logic [8:0] tb_addr = '0;
  logic [7:0] tb_d = '0;

  always @(posedge clk) begin
    code_in <= mem[code_addr[8:0]];
    data_in <= mem[data_addr[8:0]];
  end

  always @(negedge clk) begin
    if (wr_en) mem[wr_addr[8:0]] <= wr_data;
    else if (tb_we) mem[tb_addr] <= tb_d;
  end

  int n_vec = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_xfer = 0;
  int cyc = 0;
  bit log_wr = 1'b0;
  int wr_t[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] b);
    exp_q.push_back(b);
    n_push++;
  endtask

  // Scoreboard monitor: one pop per completed output handshake.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (log_wr && wr_en) wr_t.push_back(cyc);
      if (rst_n && out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) chk("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
        else chk("out_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1;
      tb_we   = 1'b1;
      tb_addr = 9'(i);
      tb_d    = (i < s.len()) ? s[i] : 8'h00;
    end
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted || error) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_done"}, {31'h0, ok}, 32'h1);
  endtask

  string prog;
  logic [7:0] saved;
  bit ok;

  initial begin
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_code_addr", {16'h0, code_addr}, 32'h0);
    chk("rst_data_addr", {16'h0, data_addr}, 32'h100);
    chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // +++. then end: one byte 0x03, writes 2 cycles apart
    load("+++.");
    expect_out(8'h03);
    log_wr = 1'b1;
    pulse_start();
    wait_done("t1");
    log_wr = 1'b0;
    chk("t1_halted", {31'h0, halted}, 32'h1);
    chk("t1_nwr", wr_t.size(), 3);
    if (wr_t.size() >= 3) begin
      chk("t1_gap01", wr_t[1] - wr_t[0], 2);
      chk("t1_gap12", wr_t[2] - wr_t[1], 2);
    end

    // cell wrap downward
    load("-.");
    expect_out(8'hFF);
    pulse_start();
    wait_done("t2a");
    chk("t2a_cell", {24'h0, mem[256]}, 32'hFF);

    // dp wrap to DATA_LEN-1
    load("<+.");
    expect_out(8'h01);
    pulse_start();
    wait_done("t2b");
    chk("t2b_cell511", {24'h0, mem[511]}, 32'h01);
    chk("t2b_cell256", {24'h0, mem[256]}, 32'h00);

    // nested forward scan skips whole loop
    load("[[+]+]+.");
    expect_out(8'h01);
    pulse_start();
    wait_done("t3");
    chk("t3_halted", {31'h0, halted}, 32'h1);

    // backward scans, loop runs down to zero
    load("+++[-].");
    expect_out(8'h00);
    pulse_start();
    wait_done("t4");
    chk("t4_cell", {24'h0, mem[256]}, 32'h00);
    chk("t4_halted", {31'h0, halted}, 32'h1);

    // input late, output back-pressured
    load(",.");
    expect_out(8'h41);
    out_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_in_ready", {31'h0, ok}, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_in_ready_held", {31'h0, in_ready}, 32'h1);
    chk("t5_no_early_wr", {31'h0, wr_en}, 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h41;
    @(negedge clk);
    chk("t5_wr_en", {31'h0, wr_en}, 32'h1);
    chk("t5_wr_data", {24'h0, wr_data}, 32'h41);
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_out_valid", {31'h0, ok}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t5_hold_valid", {31'h0, out_valid}, 32'h1);
      chk("t5_hold_data", {24'h0, out_data}, 32'h41);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("t5");
    chk("t5_cell", {24'h0, mem[256]}, 32'h41);

    // unmatched bracket scans into 0x00
    load("[+");
    pulse_start();
    wait_done("t6");
    chk("t6_error", {31'h0, error}, 32'h1);
    chk("t6_halted", {31'h0, halted}, 32'h0);

    // reset in the middle of a long forward scan
    prog = "[";
    for (int i = 0; i < 60; i++) prog = {prog, "a"};
    prog = {prog, "]+."};
    load(prog);
    pulse_start();
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t7_scan_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_wr", {31'h0, wr_en}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t7_idle_busy", {31'h0, busy}, 32'h0);
    chk("t7_idle_code_addr", {16'h0, code_addr}, 32'h0);
    expect_out(8'h01);
    pulse_start();
    wait_done("t7");
    chk("t7_halted", {31'h0, halted}, 32'h1);

    // reset landing on an EXEC write cycle suppresses the write
    prog = "";
    for (int i = 0; i < 40; i++) prog = {prog, "+"};
    prog = {prog, "."};
    load(prog);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t8_first_wr", {31'h0, ok}, 32'h1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    saved = mem[256];
    @(posedge clk);
    #1;
    chk("t8_no_wr_in_rst", {24'h0, mem[256]}, {24'h0, saved});
    rst_n = 1'b1;
    @(negedge clk);
    chk("t8_idle_busy", {31'h0, busy}, 32'h0);
    // cells persist across restart
    expect_out(saved + 8'd40);
    pulse_start();
    wait_done("t8");
    chk("t8_halted", {31'h0, halted}, 32'h1);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("xfer_count", n_xfer, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bf_seq.md
# bf_seq

Instruction sequencer for the bfX Brainfuck machine. Drives the shared code/data memory (2 read ports, 1 write port): fetches code bytes on read port 1, reads the current cell on read port 2, and issues cell writes. Exposes valid/ready byte streams for `.` and `,`, and a start/halted/error control interface.

## Interface
- `CODE_BASE`, default 0: first code address.
- `CODE_LEN`, default 256: code region size in bytes.
- `DATA_BASE`, default 256: first data-cell address.
- `DATA_LEN`, default 256: data region size; must be a power of 2.
- `DEPTH_W`, default 8: bracket-depth counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins execution from IDLE/HALT/ERROR.
- `code_addr` out 16: to memory `addr1`.
- `data_addr` out 16: to memory `addr2`.
- `code_in` in 8: from memory `out1`.
- `data_in` in 8: from memory `out2`.
- `wr_en` out 1: to memory `writeEnable`.
- `wr_addr` out 16: to `writeaddr`.
- `wr_data` out 8: to `writeData`.
- `out_valid` out 1, `out_data` out 8, `out_ready` in 1: output byte stream.
- `in_valid` in 1, `in_data` in 8, `in_ready` out 1: input byte stream.
- `busy`, `halted`, `error` out 1: status.

## Operation
- Registers: `ip` (code offset, 0..CODE_LEN-1), `dp` (cell offset, 0..DATA_LEN-1), `depth`, `state`.
- `code_addr = CODE_BASE+ip`, `data_addr = DATA_BASE+dp`.
- `wr_addr` is always `data_addr`.
- Opcodes (ASCII):
  - `+` 0x2B: cell+1.
  - `-` 0x2D: cell-1.
  - `>` 0x3E: dp+1.
  - `<` 0x3C: dp-1.
  - `.` 0x2E: output cell.
  - `,` 0x2C: input to cell.
  - `[` 0x5B, `]` 0x5D: loops.
  - 0x00: end of program, go to HALT.
  - Any other byte: NOP.
- Cell arithmetic wraps mod 256.
- dp wraps mod DATA_LEN, so `<` at dp=0 gives dp=DATA_LEN-1.
- States:
  - IDLE: after reset. On `start`: ip=0, dp=0, go to FETCH.
  - FETCH: addresses presented; go to EXEC.
  - EXEC: decode `code_in` against `data_in`.
    - `+`/`-`/`>`/`<`/NOP: ip+1, go to FETCH. `+`/`-` assert `wr_en` with `wr_data = data_in±1` this cycle.
    - `[` with cell==0: depth=1, ip+1, go to SFETCH (forward scan).
    - `[` with cell!=0: ip+1, go to FETCH.
    - `]` with cell!=0: depth=1, ip-1, go to SFETCH (backward scan).
    - `]` with cell==0: ip+1, go to FETCH.
    - `.`: go to OUT_WAIT.
    - `,`: go to IN_WAIT.
    - 0x00: go to HALT.
  - SFETCH/SCHECK: 2 cycles per scanned byte.
    - `[` increments depth on forward scan and decrements on backward scan; `]` does the opposite.
    - Depth reaching 0 on forward scan: ip = match+1, go to FETCH.
    - Depth reaching 0 on backward scan: ip = match+1 (loop body start), go to FETCH.
    - Otherwise step ip in the scan direction.
  - OUT_WAIT: `out_valid=1`, `out_data` = cell, both held stable until `out_ready`. On handshake: ip+1, go to FETCH.
  - IN_WAIT: `in_ready=1`. On `in_valid`: `wr_en=1`, `wr_data=in_data`, ip+1, go to FETCH.
  - HALT: `halted=1`.
  - ERROR: `error=1`.
  - HALT and ERROR hold until `start` (restart: ip=0, dp=0, go to FETCH; cells are not cleared) or reset.
- Errors (go to ERROR):
  - ip falls off either end of the code region during a scan, or a 0x00 byte is scanned.
  - depth would overflow 2^DEPTH_W-1.
  - In normal flow, ip+1 == CODE_LEN goes to HALT, not ERROR.
- `start` outside IDLE/HALT/ERROR is ignored.
- `busy` = state not in {IDLE, HALT, ERROR}.

## Timing
- Memory reads are registered at posedge and writes land at negedge.
  - Bytes requested in FETCH/SFETCH are valid in the following EXEC/SCHECK cycle.
  - A write in EXEC/IN_WAIT is visible to the next FETCH.
- `+ - > <` NOP take 2 cycles each.
- `.`/`,` take 2 cycles plus handshake wait; handshake completes in the cycle valid and ready are both high.
- A scan costs 2 cycles per byte examined.
- Reset values: state IDLE, ip=0, dp=0, depth=0. All outputs 0 except `code_addr=CODE_BASE` and `data_addr=DATA_BASE`.
- `rst_n` low in any state (including mid-scan or mid-handshake) returns to IDLE at the next edge; no write is issued in that cycle.
- `wr_en`, `out_valid` and `in_ready` are registered-state-decoded: no combinational path from `in_valid`/`out_ready` to `out_valid`/`in_ready`.

## Structure
- Package `bf_pkg` holds:
  - Opcode constants `OP_INC`, `OP_DEC`, `OP_RIGHT`, `OP_LEFT`, `OP_OUT`, `OP_IN`, `OP_JZ`, `OP_JNZ`, `OP_END`.
  - State enum `bf_state_t`.
  - Default region constants.
- Sub-module `bf_decode`: combinational byte-to-one-hot opcode decoder, shared by EXEC and SCHECK.

## Test plan
- Code `+++.` 0x00 → one output byte 0x03, then `halted=1`. `+`→`+` spacing is 2 cycles.
- Code `-.`, then `<+.` → outputs 0xFF, then 0x01 with mem[511]=0x01 (dp wrapped to 255).
- Code `[[+]+]+.` with cell 0 → nested forward scan skips the loop; output 0x01.
- Code `+++[-].` → backward scans execute 3 iterations; output 0x00; cell ends 0.
- Code `,.`:
  - `in_valid` asserted 3 cycles late with 0x41 → cell = 0x41.
  - `out_ready` held low 5 cycles → `out_valid`/`out_data`=0x41 stay stable; one transfer.
- Code `[+` with cell 0 → unmatched-bracket scan reaches 0x00 → `error=1`.
- Reset pulsed mid-scan → IDLE with no write; `start` reruns cleanly.
